// File: rtl/noc_pkg.sv
// Shared definitions for the mesh-router route-compute stage:
// flit type encodings, output-port codes, routing-mode selectors
// and the per-channel wormhole state.
package noc_pkg;

    // Two-bit flit type carried in the top bits of every flit
    typedef enum logic [1:0] {
        FLIT_BODY      = 2'b00,
        FLIT_TAIL      = 2'b01,
        FLIT_HEAD      = 2'b10,
        FLIT_HEAD_TAIL = 2'b11
    } flit_type_e;

    // Output-port codes presented on the crossbar select
    localparam int unsigned PORT_RESOURCE = 0;
    localparam int unsigned PORT_WEST     = 1;
    localparam int unsigned PORT_EAST     = 2;
    localparam int unsigned PORT_NORTH    = 3;
    localparam int unsigned PORT_SOUTH    = 4;

    // Dimension-order selection
    localparam int unsigned ROUTE_XY = 0;
    localparam int unsigned ROUTE_YX = 1;

    // Per-channel wormhole state: IDLE waits for a head, ROUTED holds a route
    typedef enum logic {
        CH_IDLE   = 1'b0,
        CH_ROUTED = 1'b1
    } ch_state_e;

endpackage

// File: rtl/xy_route_calc.sv
// Combinational dimension-order route function. Compares the destination
// address against this router's coordinates (unsigned, zero-extended to at
// least 32 bits) and returns the output-port select.
module xy_route_calc
    import noc_pkg::*;
#(
    parameter int unsigned X_CORD          = 0,
    parameter int unsigned Y_CORD          = 0,
    parameter int unsigned PACKET_ADDR_X_W = 4,
    parameter int unsigned PACKET_ADDR_Y_W = 4,
    parameter int unsigned OUTPUT_N_W      = 3,
    parameter int unsigned ROUTE_MODE      = 0
) (
    input  logic [PACKET_ADDR_X_W-1:0] x_addr,
    input  logic [PACKET_ADDR_Y_W-1:0] y_addr,
    output logic [OUTPUT_N_W-1:0]      sel
);

    localparam int unsigned XW = (PACKET_ADDR_X_W > 32) ? PACKET_ADDR_X_W : 32;
    localparam int unsigned YW = (PACKET_ADDR_Y_W > 32) ? PACKET_ADDR_Y_W : 32;

    logic [XW-1:0] x_ext;
    logic [XW-1:0] x_cord;
    logic [YW-1:0] y_ext;
    logic [YW-1:0] y_cord;
    logic          x_ne;
    logic          x_gt;
    logic          y_ne;
    logic          y_lt;

    assign x_ext  = XW'(x_addr);
    assign x_cord = XW'(X_CORD);
    assign y_ext  = YW'(y_addr);
    assign y_cord = YW'(Y_CORD);

    assign x_ne = (x_ext != x_cord);
    assign x_gt = (x_ext >  x_cord);
    assign y_ne = (y_ext != y_cord);
    assign y_lt = (y_ext <  y_cord);

    // Pick the first dimension that still differs, in the configured order
    always_comb begin
        sel = OUTPUT_N_W'(PORT_RESOURCE);
        if (ROUTE_MODE == ROUTE_XY) begin
            if (x_ne) begin
                sel = x_gt ? OUTPUT_N_W'(PORT_EAST) : OUTPUT_N_W'(PORT_WEST);
            end else if (y_ne) begin
                sel = y_lt ? OUTPUT_N_W'(PORT_NORTH) : OUTPUT_N_W'(PORT_SOUTH);
            end
        end else begin
            if (y_ne) begin
                sel = y_lt ? OUTPUT_N_W'(PORT_NORTH) : OUTPUT_N_W'(PORT_SOUTH);
            end else if (x_ne) begin
                sel = x_gt ? OUTPUT_N_W'(PORT_EAST) : OUTPUT_N_W'(PORT_WEST);
            end
        end
    end

endmodule

// File: rtl/xy_route_stage.sv
// Registered multi-channel route-compute stage. Each input channel has one
// output register holding the flit and its output-port select. Heads compute
// a route; body/tail flits reuse the latched route until the tail passes.
module xy_route_stage
    import noc_pkg::*;
#(
    parameter int unsigned X_CORD          = 0,
    parameter int unsigned Y_CORD          = 0,
    parameter int unsigned PACKET_ADDR_X_W = 4,
    parameter int unsigned PACKET_ADDR_Y_W = 4,
    parameter int unsigned OUTPUT_N_W      = 3,
    parameter int unsigned FLIT_W          = 16,
    parameter int unsigned N_IN            = 5,
    parameter int unsigned ROUTE_MODE      = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [N_IN*FLIT_W-1:0]       flit_i,
    input  logic [N_IN-1:0]              flit_valid_i,
    output logic [N_IN-1:0]              flit_ready_o,
    output logic [N_IN*FLIT_W-1:0]       flit_o,
    output logic [N_IN-1:0]              flit_valid_o,
    input  logic [N_IN-1:0]              flit_ready_i,
    output logic [N_IN*OUTPUT_N_W-1:0]   mux_out_sel_o,
    output logic [N_IN-1:0]              err_o
);

    localparam int unsigned ADDR_W = PACKET_ADDR_X_W + PACKET_ADDR_Y_W;

    genvar c;
    generate
        for (c = 0; c < N_IN; c++) begin : g_ch
            logic [FLIT_W-1:0]          flit_in;
            flit_type_e                 ftype;
            logic [PACKET_ADDR_X_W-1:0] x_addr;
            logic [PACKET_ADDR_Y_W-1:0] y_addr;
            logic [OUTPUT_N_W-1:0]      calc_sel;
            logic [OUTPUT_N_W-1:0]      route_q;
            logic [OUTPUT_N_W-1:0]      route_d;
            logic [OUTPUT_N_W-1:0]      sel_d;
            logic [OUTPUT_N_W-1:0]      sel_q;
            logic [FLIT_W-1:0]          flit_q;
            logic                       valid_q;
            logic                       err_q;
            logic                       err_d;
            logic                       load;
            logic                       ready;
            logic                       accept;
            ch_state_e                  state_q;
            ch_state_e                  state_d;

            assign flit_in = flit_i[c*FLIT_W +: FLIT_W];
            assign ftype   = flit_type_e'(flit_in[FLIT_W-1 -: 2]);
            assign x_addr  = flit_in[ADDR_W-1:PACKET_ADDR_Y_W];
            assign y_addr  = flit_in[PACKET_ADDR_Y_W-1:0];

            // Register can take a new flit when empty or draining this cycle
            assign ready  = !valid_q || flit_ready_i[c];
            assign accept = flit_valid_i[c] && ready;

            xy_route_calc #(
                .X_CORD          (X_CORD),
                .Y_CORD          (Y_CORD),
                .PACKET_ADDR_X_W (PACKET_ADDR_X_W),
                .PACKET_ADDR_Y_W (PACKET_ADDR_Y_W),
                .OUTPUT_N_W      (OUTPUT_N_W),
                .ROUTE_MODE      (ROUTE_MODE)
            ) u_calc (
                .x_addr (x_addr),
                .y_addr (y_addr),
                .sel    (calc_sel)
            );

            // Wormhole next-state, route latch, error flag and load decision
            always_comb begin
                state_d = state_q;
                route_d = route_q;
                err_d   = err_q;
                sel_d   = calc_sel;
                load    = 1'b0;
                if (accept) begin
                    case (ftype)
                        FLIT_HEAD: begin
                            if (state_q == CH_ROUTED) err_d = 1'b1;
                            route_d = calc_sel;
                            state_d = CH_ROUTED;
                            load    = 1'b1;
                        end
                        FLIT_HEAD_TAIL: begin
                            if (state_q == CH_ROUTED) err_d = 1'b1;
                            state_d = CH_IDLE;
                            load    = 1'b1;
                        end
                        FLIT_BODY: begin
                            if (state_q == CH_ROUTED) begin
                                sel_d = route_q;
                                load  = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        FLIT_TAIL: begin
                            if (state_q == CH_ROUTED) begin
                                sel_d   = route_q;
                                load    = 1'b1;
                                state_d = CH_IDLE;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            // State, route and output register; drains when downstream takes it
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    state_q <= CH_IDLE;
                    route_q <= '0;
                    err_q   <= 1'b0;
                    valid_q <= 1'b0;
                    flit_q  <= '0;
                    sel_q   <= '0;
                end else begin
                    state_q <= state_d;
                    route_q <= route_d;
                    err_q   <= err_d;
                    if (load) begin
                        flit_q  <= flit_in;
                        sel_q   <= sel_d;
                        valid_q <= 1'b1;
                    end else if (flit_ready_i[c]) begin
                        valid_q <= 1'b0;
                    end
                end
            end

            assign flit_ready_o[c]                          = ready;
            assign flit_valid_o[c]                          = valid_q;
            assign flit_o[c*FLIT_W +: FLIT_W]               = flit_q;
            assign mux_out_sel_o[c*OUTPUT_N_W +: OUTPUT_N_W] = sel_q;
            assign err_o[c]                                 = err_q;
        end
    endgenerate

endmodule

// File: tb/tb_xy_route_stage.sv
// Scoreboard bench for xy_route_stage: one XY and one YX instance at (2,1).
module tb_xy_route_stage;

    localparam int unsigned FW = 16;
    localparam int unsigned SW = 3;
    localparam int unsigned NC = 5;

    typedef struct {
        logic [FW-1:0] f;
        logic [SW-1:0] s;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [NC*FW-1:0] xy_fi = '0, yx_fi = '0;
    logic [NC-1:0]    xy_vi = '0, yx_vi = '0;
    logic [NC-1:0]    xy_ri = '1, yx_ri = '1;
    logic [NC-1:0]    xy_ro, yx_ro, xy_vo, yx_vo, xy_eo, yx_eo;
    logic [NC*FW-1:0] xy_fo, yx_fo;
    logic [NC*SW-1:0] xy_so, yx_so;

    int n_vec = 0;
    int n_err = 0;

    exp_t sb [2*NC][$];

    always #5 clk = ~clk;

    xy_route_stage #(.X_CORD(2), .Y_CORD(1), .N_IN(NC), .ROUTE_MODE(0)) dut_xy (
        .clk_i(clk), .rst_i(rst), .flit_i(xy_fi), .flit_valid_i(xy_vi),
        .flit_ready_o(xy_ro), .flit_o(xy_fo), .flit_valid_o(xy_vo),
        .flit_ready_i(xy_ri), .mux_out_sel_o(xy_so), .err_o(xy_eo)
    );

    xy_route_stage #(.X_CORD(2), .Y_CORD(1), .N_IN(NC), .ROUTE_MODE(1)) dut_yx (
        .clk_i(clk), .rst_i(rst), .flit_i(yx_fi), .flit_valid_i(yx_vi),
        .flit_ready_o(yx_ro), .flit_o(yx_fo), .flit_valid_o(yx_vo),
        .flit_ready_i(yx_ri), .mux_out_sel_o(yx_so), .err_o(yx_eo)
    );

    function automatic logic [FW-1:0] mk(logic [1:0] t, logic [5:0] p, logic [3:0] x, logic [3:0] y);
        return {t, p, x, y};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(int d, int ch, logic [FW-1:0] f, logic [SW-1:0] s);
        exp_t e;
        e.f = f;
        e.s = s;
        sb[d*NC+ch].push_back(e);
    endtask

    task automatic send(int d, int ch, logic [FW-1:0] f);
        if (d == 0) begin
            xy_fi[ch*FW +: FW] = f;
            xy_vi[ch] = 1'b1;
        end else begin
            yx_fi[ch*FW +: FW] = f;
            yx_vi[ch] = 1'b1;
        end
        @(posedge clk);
        #1;
        xy_vi = '0;
        yx_vi = '0;
    endtask

    // Monitor: every output transfer pops and compares the next expectation
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < NC; c++) begin
                    logic          v, r;
                    logic [FW-1:0] f;
                    logic [SW-1:0] s;
                    exp_t          e;
                    v = (d == 0) ? xy_vo[c] : yx_vo[c];
                    r = (d == 0) ? xy_ri[c] : yx_ri[c];
                    f = (d == 0) ? xy_fo[c*FW +: FW] : yx_fo[c*FW +: FW];
                    s = (d == 0) ? xy_so[c*SW +: SW] : yx_so[c*SW +: SW];
                    if (v && r) begin
                        if (sb[d*NC+c].size() == 0) begin
                            chk($sformatf("unexpected_out d%0d ch%0d", d, c), 32'(f), 32'hFFFF_FFFF);
                        end else begin
                            e = sb[d*NC+c].pop_front();
                            chk($sformatf("flit d%0d ch%0d", d, c), 32'(f), 32'(e.f));
                            chk($sformatf("sel d%0d ch%0d", d, c), 32'(s), 32'(e.s));
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [FW-1:0] h, b, t;
        int left;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_valid_xy", 32'(xy_vo), 32'h0);
        chk("rst_valid_yx", 32'(yx_vo), 32'h0);
        chk("rst_flit_xy",  xy_fo[31:0], 32'h0);
        chk("rst_sel_xy",   32'(xy_so), 32'h0);
        chk("rst_err_xy",   32'(xy_eo), 32'h0);
        chk("rst_ready_xy", 32'(xy_ro), 32'h1F);

        // XY ch0: HEAD/BODY/TAIL to (3,1) -> EAST on three consecutive cycles
        h = mk(2'b10, 6'h01, 4'd3, 4'd1);
        b = mk(2'b00, 6'h02, 4'd3, 4'd1);
        t = mk(2'b01, 6'h03, 4'd3, 4'd1);
        push(0, 0, h, 3'd2); push(0, 0, b, 3'd2); push(0, 0, t, 3'd2);
        send(0, 0, h); chk("ch0_v1", 32'(xy_vo[0]), 32'h1);
        send(0, 0, b); chk("ch0_v2", 32'(xy_vo[0]), 32'h1);
        send(0, 0, t); chk("ch0_v3", 32'(xy_vo[0]), 32'h1);
        @(posedge clk); #1;
        // A BODY now must be dropped, proving the channel returned to IDLE
        send(0, 0, mk(2'b00, 6'h04, 4'd3, 4'd1));
        chk("ch0_idle_drop_v", 32'(xy_vo[0]), 32'h0);
        chk("ch0_idle_err",    32'(xy_eo[0]), 32'h1);

        // XY ch1 HEAD_TAIL routes
        h = mk(2'b11, 6'h10, 4'd2, 4'd0); push(0, 1, h, 3'd3); send(0, 1, h);
        h = mk(2'b11, 6'h11, 4'd2, 4'd1); push(0, 1, h, 3'd0); send(0, 1, h);
        h = mk(2'b11, 6'h12, 4'd0, 4'd5); push(0, 1, h, 3'd1); send(0, 1, h);

        // YX instance: Y compared first
        h = mk(2'b10, 6'h20, 4'd3, 4'd0); push(1, 0, h, 3'd3); send(1, 0, h);
        h = mk(2'b10, 6'h21, 4'd3, 4'd1); push(1, 1, h, 3'd2); send(1, 1, h);
        h = mk(2'b10, 6'h22, 4'd0, 4'd5); push(1, 2, h, 3'd4); send(1, 2, h);

        // XY ch2 backpressure: HEAD to (2,3) -> SOUTH held for 4 cycles
        h = mk(2'b10, 6'h30, 4'd2, 4'd3);
        b = mk(2'b00, 6'h31, 4'd0, 4'd0);
        t = mk(2'b01, 6'h32, 4'd0, 4'd0);
        push(0, 2, h, 3'd4); push(0, 2, b, 3'd4); push(0, 2, t, 3'd4);
        xy_ri[2] = 1'b0;
        send(0, 2, h);
        xy_fi[2*FW +: FW] = b;
        xy_vi[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_ready",  32'(xy_ro[2]), 32'h0);
            chk("bp_flit",   32'(xy_fo[2*FW +: FW]), 32'(h));
            chk("bp_sel",    32'(xy_so[2*SW +: SW]), 32'd4);
            @(posedge clk); #1;
        end
        xy_ri[2] = 1'b1;
        @(posedge clk); #1;
        chk("bp_rel_valid", 32'(xy_vo[2]), 32'h1);
        chk("bp_rel_flit",  32'(xy_fo[2*FW +: FW]), 32'(b));
        xy_vi[2] = 1'b0;
        send(0, 2, t);

        // XY ch3: BODY while IDLE is dropped and flags an error
        chk("ch3_err0", 32'(xy_eo[3]), 32'h0);
        send(0, 3, mk(2'b00, 6'h3F, 4'd1, 4'd1));
        chk("ch3_drop_v", 32'(xy_vo[3]), 32'h0);
        chk("ch3_err1",   32'(xy_eo[3]), 32'h1);

        // XY ch4: HEAD mid-packet re-routes and flags an error
        h = mk(2'b10, 6'h05, 4'd3, 4'd1); push(0, 4, h, 3'd2); send(0, 4, h);
        chk("ch4_err0", 32'(xy_eo[4]), 32'h0);
        h = mk(2'b10, 6'h06, 4'd2, 4'd0); push(0, 4, h, 3'd3); send(0, 4, h);
        chk("ch4_err1", 32'(xy_eo[4]), 32'h1);
        t = mk(2'b01, 6'h07, 4'd9, 4'd9); push(0, 4, t, 3'd3); send(0, 4, t);
        repeat (2) @(posedge clk); #1;

        // Reset mid-packet on ch0 with a flit stuck in the register
        xy_ri[0] = 1'b0;
        send(0, 0, mk(2'b10, 6'h08, 4'd3, 4'd1));
        chk("pre_rst_v", 32'(xy_vo[0]), 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_valid", 32'(xy_vo), 32'h0);
        chk("mrst_flit0", 32'(xy_fo[FW-1:0]), 32'h0);
        chk("mrst_sel",   32'(xy_so), 32'h0);
        chk("mrst_err",   32'(xy_eo), 32'h0);
        xy_ri[0] = 1'b1;
        send(0, 0, mk(2'b00, 6'h09, 4'd3, 4'd1));
        chk("post_rst_drop_v", 32'(xy_vo[0]), 32'h0);
        chk("post_rst_err",    32'(xy_eo[0]), 32'h1);
        h = mk(2'b10, 6'h0A, 4'd0, 4'd5); push(0, 0, h, 3'd1); send(0, 0, h);
        t = mk(2'b01, 6'h0B, 4'd2, 4'd1); push(0, 0, t, 3'd1); send(0, 0, t);

        repeat (4) @(posedge clk); #1;
        left = 0;
        for (int i = 0; i < 2*NC; i++) left += sb[i].size();
        chk("sb_drained", 32'(left), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
